host_reg_slave: RTL and testbench

Parametrised host-interface slave endpoint that terminates host read/write commands into a local bank of NUM_REGS software-visible registers. It generalises the fixed 32-bit, single-outstanding host interface with configurable widths, byte enables, and command backpressure. It also adds a configurable read latency, multiple outstanding reads with response backpressure, and out-of-range error reporting. It sits between the host command bus and block-level control logic, which consumes reg_q and wr_pulse.

---
 rtl/host_reg_slave_pkg.sv | 19 +
 rtl/host_reg_slave_rsp_fifo.sv | 53 +++++
 rtl/host_reg_slave.sv | 140 ++++++++++++++
 tb/tb_host_reg_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_reg_slave_pkg.sv
// Address decode helpers shared by the host register slave.
// Pure functions, no state.
// No flow control of its own.
package host_pkg;

    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int          data_w);
        return (addr - base) >> $clog2(data_w / 8);
    endfunction

    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input int          data_w,
                                      input int          num_regs);
        return (addr >= base) && (addr_to_idx(addr, base, data_w) < 64'(num_regs));
    endfunction

endpackage

// File: rtl/host_reg_slave_rsp_fifo.sv
// First-word-fall-through FIFO carrying read responses back to the host.
// Zero-cycle read latency: head entry is on pop_dat while !empty.
// Push is dropped when full, pop is ignored when empty; pop_dat reads zero when empty.
module host_rsp_fifo #(
    parameter type dat_t = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  dat_t push_dat,
    input  logic pop,
    output dat_t pop_dat,
    output logic empty,
    output logic full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    dat_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        pop_dat = '0;
        if (!empty) pop_dat = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/host_reg_slave.sv
// Host command endpoint terminating reads/writes into a bank of NUM_REGS registers.
// Writes land on the accept edge; read data appears RD_LATENCY cycles after accept.
// cmd_rdy drops while MAX_OUTSTANDING reads are unreturned; responses held until rd_rdy.
module host_reg_slave
    import host_pkg::*;
#(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter int                NUM_REGS        = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
    parameter int                RD_LATENCY      = 2,
    parameter int                MAX_OUTSTANDING = 4,
    parameter logic [DATA_W-1:0] REG_RST         = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_vld,
    output logic                         cmd_rdy,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         rw,
    input  logic [DATA_W-1:0]            data_w,
    input  logic [DATA_W/8-1:0]          be,
    output logic [DATA_W-1:0]            data_r,
    output logic                         rd_err,
    output logic                         rd_vld,
    input  logic                         rd_rdy,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic [7:0]                   err_cnt
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  out_nxt;
    logic [IDX_W-1:0]  cmd_idx;
    logic              cmd_acc;
    logic              cmd_hit;
    logic              rd_acc;
    logic              rd_pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    rsp_t              rd_rsp;
    rsp_t              fifo_in;
    rsp_t              fifo_out;

    assign cmd_acc     = cmd_vld && cmd_rdy;
    assign cmd_hit     = in_range(64'(addr), 64'(BASE_ADDR), DATA_W, NUM_REGS);
    assign cmd_idx     = IDX_W'(addr_to_idx(64'(addr), 64'(BASE_ADDR), DATA_W));
    assign rd_acc      = cmd_acc && !rw;
    assign rd_pop      = rd_vld && rd_rdy;
    // Sampled on the accept edge, so any earlier accepted write is already in regs.
    assign rd_rsp.data = cmd_hit ? regs[cmd_idx] : '0;
    assign rd_rsp.err  = !cmd_hit;
    assign out_nxt     = outstanding + OUT_W'(rd_acc) - OUT_W'(rd_pop);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
        assign reg_q[i*DATA_W +: DATA_W] = regs[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RST;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (cmd_acc && rw && cmd_hit && (be != '0)) begin
                wr_pulse[cmd_idx] <= 1'b1;
                for (int k = 0; k < BE_W; k++) begin
                    if (be[k]) regs[cmd_idx][8*k +: 8] <= data_w[8*k +: 8];
                end
            end
        end
    end

    // Outstanding counts reads in the pipeline and the FIFO, so gating on it keeps the FIFO from overflowing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            cmd_rdy     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            outstanding <= out_nxt;
            cmd_rdy     <= (out_nxt < OUT_W'(MAX_OUTSTANDING));
            if (cmd_acc && !cmd_hit && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

    if (RD_LATENCY == 1) begin : g_no_pipe
        assign fifo_push = rd_acc;
        assign fifo_in   = rd_rsp;
    end else begin : g_pipe
        logic [RD_LATENCY-2:0] pipe_vld;
        rsp_t                  pipe_rsp [RD_LATENCY-1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pipe_vld <= '0;
                for (int i = 0; i < RD_LATENCY - 1; i++) pipe_rsp[i] <= '0;
            end else begin
                pipe_vld[0] <= rd_acc;
                pipe_rsp[0] <= rd_rsp;
                for (int i = 1; i < RD_LATENCY - 1; i++) begin
                    pipe_vld[i] <= pipe_vld[i-1];
                    pipe_rsp[i] <= pipe_rsp[i-1];
                end
            end
        end

        assign fifo_push = pipe_vld[RD_LATENCY-2];
        assign fifo_in   = pipe_rsp[RD_LATENCY-2];
    end

    host_rsp_fifo #(
        .dat_t (rsp_t),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push && !fifo_full),
        .push_dat (fifo_in),
        .pop      (rd_pop),
        .pop_dat  (fifo_out),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign rd_vld = !fifo_empty;
    assign data_r = fifo_out.data;
    assign rd_err = fifo_out.err;

endmodule

// File: tb/tb_host_reg_slave.sv
// Randomised scoreboard bench for host_reg_slave against a behavioural register-bank model.
module tb_host_reg_slave;
    localparam int          NUM  = 16;
    localparam int          LAT  = 3;
    localparam int          MAXO = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] RST  = 32'h5A5A_0000;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              cmd_vld;
    logic              cmd_rdy;
    logic [31:0]       addr;
    logic              rw;
    logic [31:0]       data_w;
    logic [3:0]        be;
    logic [31:0]       data_r;
    logic              rd_err;
    logic              rd_vld;
    logic              rd_rdy;
    logic [NUM*32-1:0] reg_q;
    logic [NUM-1:0]    wr_pulse;
    logic [7:0]        err_cnt;

    logic man_rdy;
    logic rnd_rdy;
    logic rnd_en;
    assign rd_rdy = rnd_en ? rnd_rdy : man_rdy;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int n_acc      = 0;
    int last_acc   = 0;

    logic [31:0]    m_regs [NUM];
    int             m_err;
    exp_t           exp_q [$];
    logic [NUM-1:0] pulse_exp [int];

    host_reg_slave #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .NUM_REGS        (NUM),
        .BASE_ADDR       (BASE),
        .RD_LATENCY      (LAT),
        .MAX_OUTSTANDING (MAXO),
        .REG_RST         (RST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .addr     (addr),
        .rw       (rw),
        .data_w   (data_w),
        .be       (be),
        .data_r   (data_r),
        .rd_err   (rd_err),
        .rd_vld   (rd_vld),
        .rd_rdy   (rd_rdy),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse),
        .err_cnt  (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic void chk(input string nm, input logic [NUM*32-1:0] act, input logic [NUM*32-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [NUM*32-1:0] model_flat();
        logic [NUM*32-1:0] f;
        for (int i = 0; i < NUM; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM; i++) m_regs[i] = RST;
        m_err = 0;
        exp_q.delete();
        pulse_exp.delete();
    endfunction

    // Applies one accepted command to the model; acc is the cycle number of the accept edge.
    function automatic void model_accept(input logic w, input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] b, input int acc);
        bit   hit;
        int   idx;
        exp_t e;
        hit = (a >= BASE) && (((a - BASE) / 4) < NUM);
        idx = hit ? int'((a - BASE) / 4) : 0;
        n_acc++;
        if (!hit) m_err = (m_err >= 255) ? 255 : m_err + 1;
        if (w) begin
            if (hit && b != 4'h0) begin
                for (int k = 0; k < 4; k++) if (b[k]) m_regs[idx][8*k +: 8] = d[8*k +: 8];
                pulse_exp[acc] = NUM'(1) << idx;
            end
        end else begin
            e.data = hit ? m_regs[idx] : 32'h0;
            e.err  = !hit;
            e.acc  = acc;
            exp_q.push_back(e);
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int waitc;
        waitc   = 0;
        cmd_vld = 1'b1;
        rw      = w;
        addr    = a;
        data_w  = d;
        be      = b;
        @(negedge clk);
        while (!cmd_rdy && waitc < 500) begin
            waitc++;
            @(negedge clk);
        end
        if (!cmd_rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_accept: cmd_rdy stayed %0b, expected 1 within 500 cycles", cmd_rdy);
            cmd_vld = 1'b0;
            return;
        end
        model_accept(w, a, d, b, cyc + 1);
        @(posedge clk);
        #1;
        cmd_vld  = 1'b0;
        last_acc = cyc;
        chk("reg_q", reg_q, model_flat());
        chk("err_cnt", err_cnt, m_err);
    endtask

    task automatic drain();
        int n;
        n       = 0;
        rnd_en  = 1'b0;
        man_rdy = 1'b1;
        while ((exp_q.size() != 0 || rd_vld) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard: pops on each handshake, checks order, data, hold stability and earliest timing.
    initial begin
        exp_t        e;
        logic        hold;
        logic [32:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("rsp_hold", {rd_vld, rd_err, data_r}, {1'b1, held});
                if (rd_vld && rd_rdy) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_rsp: got err=%0b data=%0h, expected no response", rd_err, data_r);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_data", {rd_err, data_r}, {e.err, e.data});
                        chk("rsp_not_early", (cyc - e.acc + 1 >= LAT), 1);
                    end
                end
                hold = rd_vld && !rd_rdy;
                held = {rd_err, data_r};
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("wr_pulse", wr_pulse, pulse_exp.exists(cyc) ? pulse_exp[cyc] : '0);
            pulse_exp.delete(cyc);
        end
    end

    initial begin
        int t0;
        int n;
        int a1;
        reset   = 1'b0;
        cmd_vld = 1'b0;
        rw      = 1'b0;
        addr    = '0;
        data_w  = '0;
        be      = '0;
        man_rdy = 1'b1;
        rnd_en  = 1'b0;
        model_reset();

        #12;
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_data_err", {rd_err, data_r}, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_reg_q", reg_q, {NUM{RST}});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_cmd_rdy", cmd_rdy, 1);
        @(posedge clk);
        #1;

        // Byte-enable merge, then a be=0 write that must neither change nor pulse.
        issue(1'b1, BASE, 32'h0, 4'hF);
        issue(1'b1, BASE, 32'hAABBCCDD, 4'b0101);
        chk("be_merge", reg_q[31:0], 32'h00BB00DD);
        issue(1'b1, BASE + 2, 32'h11223344, 4'h0);
        chk("be_zero", reg_q[31:0], 32'h00BB00DD);

        // Reset in the middle of a burst of three reads.
        man_rdy = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b0, BASE + 4 * $urandom_range(0, NUM - 1), 32'h0, 4'h0);
        reset = 1'b0;
        #1;
        chk("rstmid_cmd_rdy", cmd_rdy, 0);
        chk("rstmid_rd_vld", rd_vld, 0);
        chk("rstmid_reg_q", reg_q, {NUM{RST}});
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b1;
        man_rdy = 1'b1;
        @(negedge clk);
        chk("rstmid_rel_cmd_rdy", cmd_rdy, 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;

        // Out-of-range reads and writes.
        issue(1'b0, BASE + 4 * NUM, 32'h0, 4'h0);
        chk("oor_err1", err_cnt, 1);
        issue(1'b1, BASE + 4 * NUM + 4, 32'hFFFF_FFFF, 4'hF);
        chk("oor_err2", err_cnt, 2);
        issue(1'b0, BASE - 4, 32'h0, 4'h0);
        issue(1'b0, BASE + 4 * NUM - 1, 32'h0, 4'h0);
        drain();

        // Read latency into an empty response path.
        issue(1'b1, BASE + 8, 32'h1234, 4'hF);
        drain();
        issue(1'b0, BASE + 8, 32'h0, 4'h0);
        t0 = cyc;
        n  = 0;
        while (!rd_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_latency", cyc - t0 + 1, LAT);
        drain();

        // Write then read the same register on consecutive accepts.
        issue(1'b1, BASE + 20, 32'hDEAD, 4'hF);
        a1 = last_acc;
        issue(1'b0, BASE + 20, 32'h0, 4'h0);
        chk("wtr_back_to_back", last_acc - a1, 1);
        drain();

        // Accept and pop on the same edge with three outstanding.
        man_rdy = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b0, BASE + 4 * i, 32'h0, 4'h0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        issue(1'b0, BASE + 12, 32'h0, 4'h0);
        chk("simul_cmd_rdy", cmd_rdy, 1);
        drain();

        // Response backpressure: fifth command held until a response is taken.
        man_rdy = 1'b0;
        for (int i = 0; i < MAXO; i++) issue(1'b0, BASE + 4 * $urandom_range(0, NUM - 1), 32'h0, 4'h0);
        @(negedge clk);
        chk("bp_cmd_rdy_low", cmd_rdy, 0);
        @(posedge clk);
        #1;
        a1 = n_acc;
        fork
            issue(1'b0, BASE + 4, 32'h0, 4'h0);
        join_none
        repeat (6) @(negedge clk);
        chk("bp_fifth_held", n_acc, a1);
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        wait fork;
        chk("bp_fifth_taken", n_acc, a1 + 1);
        drain();

        // Random mix with random response backpressure.
        rnd_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, 1) == 1,
                  BASE - 8 + $urandom_range(0, 4 * NUM + 15),
                  $urandom, 4'($urandom_range(0, 15)));
        end
        drain();

        // Enough out-of-range commands to saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            issue(i[0], (i % 7 == 0) ? BASE - 4 : BASE + 4 * NUM + 4 * $urandom_range(0, 100),
                  $urandom, 4'hF);
        end
        chk("err_saturated", err_cnt, 255);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
